simd_fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the decode/controller stage of the SIMD AES core.
- Keeps the program counter and drives a synchronous instruction ROM (1-cycle read latency).
- Registers each returned 20-bit instruction word and its PC into an IF/ID register consumed by the controller.
- Supports stall, branch redirect with squash of the in-flight fetch, and an optional halt.

---
 rtl/simd_fetch_stage.sv | 118 +++++++++++
 tb/tb_simd_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_fetch_stage.sv
// simd_fetch_stage
//   Instruction fetch stage feeding the decode/controller stage of the SIMD AES core.
//   Holds the program counter and addresses a synchronous instruction ROM with a
//   1-cycle read latency. Each returned word is registered, together with its PC,
//   into the IF/ID register. The stage supports stall, branch redirect with squash
//   of the in-flight fetch, and an optional halt.
//
// Optional feature macro: FETCH_HALT_EN
//   Defined   : a valid instruction whose opcode matches HALT_OPCODE freezes fetch
//               until rst.
//   Undefined : halted is constant 0, and HALT_OPCODE is an ordinary opcode.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   stall          in   hold PC and IF/ID register
//   branch_taken   in   one-cycle redirect request (wins over stall)
//   branch_target  in   redirect address, valid with branch_taken
//   imem_addr      out  ROM read address (current PC)
//   imem_rdata     in   ROM data for the address presented on the previous edge
//   instr_out      out  IF/ID instruction word
//   pc_out         out  PC of instr_out
//   instr_valid    out  instr_out is a real instruction (0 = bubble)
//   halted         out  fetch stopped by a halt instruction
module simd_fetch_stage #(
    parameter int unsigned BITS        = 20,
    parameter int unsigned PC_W        = 10,
    parameter int unsigned RESET_PC    = 0,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [BITS-1:0] imem_rdata,
    output logic [BITS-1:0] instr_out,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    output logic            halted
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic            req_valid_q;
    logic [BITS-1:0] instr_q;
    logic [PC_W-1:0] pc_out_q;
    logic            instr_valid_q;
    logic            halted_q;

    // While stalled the ROM keeps reading the current PC, which is one ahead of
    // the word that was in flight. The in-flight word is parked here on the
    // first stalled edge and used on release so nothing is skipped.
    logic [BITS-1:0] held_word_q;
    logic            held_q;

    logic [BITS-1:0] fetch_word;
    logic            halt_hit;

    always_comb begin
        fetch_word = held_q ? held_word_q : imem_rdata;
        halt_hit   = HALT_EN && req_valid_q && (fetch_word[BITS-1 -: 5] == HALT_OPCODE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RST_PC;
            fetch_pc_q    <= RST_PC;
            req_valid_q   <= 1'b0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            held_word_q   <= '0;
            held_q        <= 1'b0;
        end else if (halted_q) begin
            // Frozen: branch and stall are ignored, only bubbles leave the stage.
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else if (branch_taken) begin
            // Squash both the IF/ID entry and the word the ROM is returning.
            pc_q          <= branch_target;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            held_q        <= 1'b0;
        end else if (stall) begin
            if (!held_q) begin
                held_word_q <= imem_rdata;
                held_q      <= 1'b1;
            end
        end else begin
            pc_q          <= pc_q + 1'b1;
            fetch_pc_q    <= pc_q;
            req_valid_q   <= 1'b1;
            instr_q       <= fetch_word;
            pc_out_q      <= fetch_pc_q;
            instr_valid_q <= req_valid_q;
            held_q        <= 1'b0;
            halted_q      <= halt_hit;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_simd_fetch_stage.sv
// Directed testbench for simd_fetch_stage. A 10-bit-PC instance covers streaming,
// stall, branch and halt; a 4-bit-PC instance covers PC wrap and async reset.
module tb_simd_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic [19:0] instr_out;
    logic [9:0]  pc_out;
    logic        instr_valid;
    logic        halted;

    logic        rst2;
    logic        stall2;
    logic        branch_taken2;
    logic [3:0]  branch_target2;
    logic [3:0]  imem_addr2;
    logic [19:0] imem_rdata2;
    logic [19:0] instr_out2;
    logic [3:0]  pc_out2;
    logic        instr_valid2;
    logic        halted2;

    logic [19:0] rom  [1024];
    logic [19:0] rom2 [16];

    int pass_cnt;
    int total_cnt;

    simd_fetch_stage #(.BITS(20), .PC_W(10), .RESET_PC(0), .HALT_OPCODE(5'b11111)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    simd_fetch_stage #(.BITS(20), .PC_W(4), .RESET_PC(0), .HALT_OPCODE(5'b11111)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .stall        (stall2),
        .branch_taken (branch_taken2),
        .branch_target(branch_target2),
        .imem_addr    (imem_addr2),
        .imem_rdata   (imem_rdata2),
        .instr_out    (instr_out2),
        .pc_out       (pc_out2),
        .instr_valid  (instr_valid2),
        .halted       (halted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROMs, one-cycle read latency.
    always_ff @(posedge clk) begin
        imem_rdata  <= rom[imem_addr];
        imem_rdata2 <= rom2[imem_addr2];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Reset values, then stream ROM[0..4] from the 2nd edge after release.
    task automatic test_reset();
        rst = 1'b1;
        step();
        total_cnt++;
        if (instr_out !== 20'h0 || pc_out !== 10'h0 || instr_valid !== 1'b0 ||
            imem_addr !== 10'h0 || halted !== 1'b0) begin
            $display("FAIL reset_state: got instr=%h pc=%h v=%b addr=%h h=%b required all 0",
                     instr_out, pc_out, instr_valid, imem_addr, halted);
        end else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'd1) begin
            $display("FAIL first_edge: got v=%b addr=%h required v=0 addr=001",
                     instr_valid, imem_addr);
        end else pass_cnt++;
        for (int k = 2; k <= 6; k++) begin
            step();
            total_cnt++;
            if (instr_out !== 20'h01000 + 20'(k - 2) || pc_out !== 10'(k - 2) ||
                instr_valid !== 1'b1) begin
                $display("FAIL stream_%0d: got instr=%h pc=%h v=%b required instr=%h pc=%h v=1",
                         k, instr_out, pc_out, instr_valid, 20'h01000 + 20'(k - 2), 10'(k - 2));
            end else pass_cnt++;
        end
    endtask

    // Continues from test_reset: instr_out=ROM[4], PC=6.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (instr_out !== 20'h01004 || pc_out !== 10'd4 || instr_valid !== 1'b1 ||
                imem_addr !== 10'd6) begin
                $display("FAIL stall_hold_%0d: got instr=%h pc=%h v=%b addr=%h required 01004 004 1 006",
                         i, instr_out, pc_out, instr_valid, imem_addr);
            end else pass_cnt++;
        end
        stall = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            step();
            total_cnt++;
            if (instr_out !== 20'h01000 + 20'(i) || pc_out !== 10'(i) || instr_valid !== 1'b1) begin
                $display("FAIL stall_release_%0d: got instr=%h pc=%h v=%b required instr=%h pc=%h v=1",
                         i, instr_out, pc_out, instr_valid, 20'h01000 + 20'(i), 10'(i));
            end else pass_cnt++;
        end
    endtask

    task automatic test_branch();
        reset1();
        for (int i = 0; i < 7; i++) step();
        total_cnt++;
        if (imem_addr !== 10'd7 || instr_out !== 20'h01005) begin
            $display("FAIL branch_setup: got addr=%h instr=%h required 007 01005", imem_addr, instr_out);
        end else pass_cnt++;
        branch_taken = 1'b1;
        branch_target = 10'h040;
        step();
        branch_taken = 1'b0;
        total_cnt++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'h040 || instr_out !== 20'h01005 ||
            pc_out !== 10'd5) begin
            $display("FAIL branch_edge: got v=%b addr=%h instr=%h pc=%h required 0 040 01005 005",
                     instr_valid, imem_addr, instr_out, pc_out);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL branch_bubble: got v=%b required 0", instr_valid);
        end else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (instr_out !== 20'h01040 + 20'(i) || pc_out !== 10'h040 + 10'(i) ||
                instr_valid !== 1'b1) begin
                $display("FAIL branch_target_%0d: got instr=%h pc=%h v=%b required instr=%h pc=%h v=1",
                         i, instr_out, pc_out, instr_valid, 20'h01040 + 20'(i), 10'h040 + 10'(i));
            end else pass_cnt++;
        end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 10'h020;
        step();
        total_cnt++;
        if (imem_addr !== 10'h020 || instr_valid !== 1'b0) begin
            $display("FAIL branch_over_stall: got addr=%h v=%b required 020 0", imem_addr, instr_valid);
        end else pass_cnt++;
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        total_cnt++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL branch_stall_bubble: got v=%b required 0", instr_valid);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 20'h01020 || pc_out !== 10'h020 || instr_valid !== 1'b1) begin
            $display("FAIL branch_stall_target: got instr=%h pc=%h v=%b required 01020 020 1",
                     instr_out, pc_out, instr_valid);
        end else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc [4];
        exp_pc[0] = 4'd14;
        exp_pc[1] = 4'd15;
        exp_pc[2] = 4'd0;
        exp_pc[3] = 4'd1;
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        branch_taken2 = 1'b1;
        branch_target2 = 4'd14;
        step();
        branch_taken2 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (pc_out2 !== exp_pc[i] || instr_out2 !== 20'h02000 + 20'(exp_pc[i]) ||
                instr_valid2 !== 1'b1) begin
                $display("FAIL wrap_%0d: got pc=%h instr=%h v=%b required pc=%h instr=%h v=1",
                         i, pc_out2, instr_out2, instr_valid2, exp_pc[i], 20'h02000 + 20'(exp_pc[i]));
            end else pass_cnt++;
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #3;
        rst2 = 1'b1;
        #1;
        total_cnt++;
        if (instr_out2 !== 20'h0 || pc_out2 !== 4'h0 || instr_valid2 !== 1'b0 ||
            imem_addr2 !== 4'h0 || halted2 !== 1'b0) begin
            $display("FAIL async_reset: got instr=%h pc=%h v=%b addr=%h h=%b required all 0",
                     instr_out2, pc_out2, instr_valid2, imem_addr2, halted2);
        end else pass_cnt++;
    endtask

    task automatic test_halt();
        rom[3] = 20'hF8000;
        reset1();
        for (int i = 0; i < 4; i++) step();
        total_cnt++;
        if (halted !== 1'b0 || instr_out !== 20'h01002) begin
            $display("FAIL pre_halt: got h=%b instr=%h required 0 01002", halted, instr_out);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 20'hF8000 || pc_out !== 10'd3 || instr_valid !== 1'b1) begin
            $display("FAIL halt_word: got instr=%h pc=%h v=%b required F8000 003 1",
                     instr_out, pc_out, instr_valid);
        end else pass_cnt++;
`ifdef FETCH_HALT_EN
        total_cnt++;
        if (halted !== 1'b1) begin
            $display("FAIL halt_set: got h=%b required 1", halted);
        end else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            branch_taken = (i % 2 == 0);
            branch_target = 10'h010;
            step();
            total_cnt++;
            if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 10'd5) begin
                $display("FAIL halt_frozen_%0d: got v=%b h=%b addr=%h required 0 1 005",
                         i, instr_valid, halted, imem_addr);
            end else pass_cnt++;
        end
        branch_taken = 1'b0;
`else
        total_cnt++;
        if (halted !== 1'b0) begin
            $display("FAIL halt_off: got h=%b required 0", halted);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 20'h01004 || pc_out !== 10'd4 || instr_valid !== 1'b1 ||
            halted !== 1'b0) begin
            $display("FAIL halt_off_next: got instr=%h pc=%h v=%b h=%b required 01004 004 1 0",
                     instr_out, pc_out, instr_valid, halted);
        end else pass_cnt++;
`endif
        rom[3] = 20'h01003;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 20'h01000 + 20'(i);
        for (int i = 0; i < 16; i++) rom2[i] = 20'h02000 + 20'(i);
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        rst2 = 1'b1;
        stall2 = 1'b0;
        branch_taken2 = 1'b0;
        branch_target2 = '0;

        test_reset();
        test_stall();
        test_branch();
        test_branch_stall();
        test_wrap();
        test_halt();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
